// File: rtl/fpu_dispatch_if.sv
// Request/response and execution-unit signal bundle for the FPU dispatcher.
// The slave modport is the dispatcher; the master modport is the requester and unit side.
interface fpu_dispatch_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned N_OPS = 5,
    parameter int unsigned TAG_W = 4
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_opcode;
    logic [2:0]           req_rm;
    logic [W-1:0]         req_a;
    logic [W-1:0]         req_b;
    logic [TAG_W-1:0]     req_tag;

    logic [W-1:0]         unit_in1;
    logic [W-1:0]         unit_in2;
    logic [2:0]           unit_rm;
    logic                 unit_rst;
    logic [N_OPS-1:0]     unit_act;
    logic [N_OPS-1:0]     unit_done;
    logic [N_OPS*W-1:0]   unit_out;
    logic [N_OPS*5-1:0]   unit_flags;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [W-1:0]         rsp_data;
    logic [4:0]           rsp_flags;
    logic [TAG_W-1:0]     rsp_tag;
    logic                 rsp_err;

    modport slave (
        input  req_valid, req_opcode, req_rm, req_a, req_b, req_tag,
        input  unit_done, unit_out, unit_flags, rsp_ready,
        output req_ready, unit_in1, unit_in2, unit_rm, unit_rst, unit_act,
        output rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err
    );

    modport master (
        output req_valid, req_opcode, req_rm, req_a, req_b, req_tag,
        output unit_done, unit_out, unit_flags, rsp_ready,
        input  req_ready, unit_in1, unit_in2, unit_rm, unit_rst, unit_act,
        input  rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err
    );
endinterface

// File: rtl/fpu_dispatch.sv
// Dispatches one FP operation at a time to a selected execution unit, with unit
// reset pulse, done/timeout completion, response handshake and sticky exception flags.
module fpu_dispatch #(
    parameter int unsigned W      = 32,
    parameter int unsigned N_OPS  = 5,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned TO_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    fpu_dispatch_if.slave bus,
    output logic [4:0]  sticky_flags,
    input  logic        sticky_clr
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned FLG_W = 5;
    localparam logic [FLG_W-1:0] FLG_INV = 5'b00100;

    typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, rm_q;
    logic [W-1:0]       a_q, b_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       rsp_data_q;
    logic [FLG_W-1:0]   rsp_flags_q;
    logic               rsp_err_q;
    logic [FLG_W-1:0]   sticky_q;

    logic               accept;
    logic               enter_resp;
    logic [W-1:0]       nxt_data;
    logic [FLG_W-1:0]   nxt_flags;
    logic               nxt_err;
    logic               sel_done;
    logic [W-1:0]       sel_out;
    logic [FLG_W-1:0]   sel_flags;
    logic               timeout;

    // Select the active unit's done/result; all other units are ignored.
    always_comb begin
        sel_done  = 1'b0;
        sel_out   = '0;
        sel_flags = '0;
        for (int unsigned i = 0; i < N_OPS; i++) begin
            if (32'(op_q) == i) begin
                sel_done  = bus.unit_done[i];
                sel_out   = bus.unit_out[i*W +: W];
                sel_flags = bus.unit_flags[i*FLG_W +: FLG_W];
            end
        end
    end

    assign timeout = (cnt_q == CNT_W'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state plus the response payload captured on entry to RESP.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        nxt_data   = '0;
        nxt_flags  = FLG_INV;
        nxt_err    = 1'b1;
        case (state_q)
            IDLE: begin
                accept = bus.req_valid;
                if (bus.req_valid) begin
                    if (32'(bus.req_opcode) < N_OPS) begin
                        state_d = CLR;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            CLR: state_d = RUN;
            RUN: begin
                if (sel_done) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                    nxt_data   = sel_out;
                    nxt_flags  = sel_flags;
                    nxt_err    = 1'b0;
                end else if (timeout) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE) && !rst;
        bus.rsp_valid = (state_q == RESP) && !rst;
        bus.unit_rst  = rst || (state_q == CLR);
        bus.unit_act  = '0;
        bus.unit_in1  = '0;
        bus.unit_in2  = '0;
        bus.unit_rm   = '0;
        if (state_q == RUN && !rst) bus.unit_act = N_OPS'(1) << op_q;
        if (state_q == CLR || state_q == RUN) begin
            bus.unit_in1 = a_q;
            bus.unit_in2 = b_q;
            bus.unit_rm  = rm_q;
        end
        bus.rsp_data  = rsp_data_q;
        bus.rsp_flags = rsp_flags_q;
        bus.rsp_tag   = tag_q;
        bus.rsp_err   = rsp_err_q;
        sticky_flags  = sticky_q;
    end

    // Operand latch, RUN counter, response registers and sticky accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '0;
            rm_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            sticky_q    <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus.req_opcode;
                rm_q  <= bus.req_rm;
                a_q   <= bus.req_a;
                b_q   <= bus.req_b;
                tag_q <= bus.req_tag;
            end
            cnt_q <= (state_q == RUN) ? cnt_q + CNT_W'(1) : '0;
            if (enter_resp) begin
                rsp_data_q  <= nxt_data;
                rsp_flags_q <= nxt_flags;
                rsp_err_q   <= nxt_err;
            end
            if (sticky_clr)      sticky_q <= enter_resp ? nxt_flags : '0;
            else if (enter_resp) sticky_q <= sticky_q | nxt_flags;
        end
    end
endmodule

// File: tb/tb_fpu_dispatch.sv
// Randomized self-checking bench for fpu_dispatch against a transaction-level
// model of response timing, payload and sticky flags.
module tb_fpu_dispatch;
    localparam int unsigned W  = 32;
    localparam int unsigned N  = 5;
    localparam int unsigned TW = 4;
    localparam int unsigned TO = 64;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sticky_clr = 1'b0;
    logic [4:0] sticky_flags;
    logic [4:0] sticky_m = '0;
    int n_tests = 0;
    int n_fail  = 0;

    fpu_dispatch_if #(.W(W), .N_OPS(N), .TAG_W(TW)) bus ();

    fpu_dispatch #(.W(W), .N_OPS(N), .TAG_W(TW), .TO_CYC(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Unit side: random noise everywhere, selected unit optionally signalling done.
    task automatic drive_units(input int op, input bit fire, input logic [31:0] out, input logic [4:0] flg);
        for (int i = 0; i < int'(N); i++) begin
            bus.unit_out[i*W +: W]   = $urandom;
            bus.unit_flags[i*5 +: 5] = 5'($urandom);
        end
        bus.unit_done = N'($urandom);
        if (op < int'(N)) begin
            bus.unit_done[op]          = fire;
            bus.unit_out[op*W +: W]    = out;
            bus.unit_flags[op*5 +: 5]  = flg;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        sticky_clr = 1'b0;
        @(negedge clk);
        check("rst_ctl", {bus.req_ready, bus.rsp_valid, bus.unit_act, bus.unit_rst}, {2'b00, 5'b0, 1'b1});
        check("rst_rsp", {bus.rsp_data, bus.rsp_flags, bus.rsp_err, bus.rsp_tag}, '0);
        check("rst_unit", {bus.unit_in1, bus.unit_in2, bus.unit_rm}, '0);
        check("rst_sticky", sticky_flags, 5'b0);
        sticky_m = '0;
        rst = 1'b0;
        #1;
        check("ready_after_rst", bus.req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_quiet", {bus.rsp_valid, bus.req_ready, bus.unit_act}, {1'b0, 1'b1, 5'b0});
        end
    endtask

    // One request from IDLE through the response handshake, compared against the model.
    task automatic txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [2:0] rm, input int d,
                       input logic [31:0] out, input logic [4:0] flg,
                       input int hold, input bit clr, input int rst_at);
        int resp_cyc;
        logic [31:0] e_data;
        logic [4:0]  e_flags;
        logic        e_err;
        logic [N-1:0] oh;
        bit valid_op, run;
        valid_op = (int'(op) < int'(N));
        if (!valid_op) begin
            resp_cyc = 1; e_data = '0; e_flags = 5'b00100; e_err = 1'b1;
        end else if (d < int'(TO)) begin
            resp_cyc = d + 3; e_data = out; e_flags = flg; e_err = 1'b0;
        end else begin
            resp_cyc = 2 + int'(TO); e_data = '0; e_flags = 5'b00100; e_err = 1'b1;
        end
        oh = '0;
        if (valid_op) oh[op] = 1'b1;

        check("req_ready", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1; bus.req_opcode = op; bus.req_a = a; bus.req_b = b;
        bus.req_tag = tag; bus.req_rm = rm;
        sticky_clr = clr && (resp_cyc == 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a = $urandom; bus.req_b = $urandom; bus.req_tag = 4'($urandom);

        for (int c = 1; c < resp_cyc; c++) begin
            if (rst_at == c) begin
                do_reset();
                return;
            end
            run = valid_op && c >= 2;
            check("ctl", {bus.rsp_valid, bus.unit_rst, bus.unit_act}, {1'b0, (c == 1), run ? oh : N'(0)});
            check("opnd", {bus.unit_in1, bus.unit_in2, bus.unit_rm}, {a, b, rm});
            drive_units(int'(op), run && (c - 2 == d), out, flg);
            sticky_clr = clr && (c == resp_cyc - 1);
            @(negedge clk);
        end
        sticky_clr = 1'b0;
        sticky_m = clr ? e_flags : (sticky_m | e_flags);

        for (int h = 0; h <= hold; h++) begin
            check("rsp_ctl", {bus.rsp_valid, bus.req_ready, bus.unit_act, bus.unit_rst}, {2'b10, 5'b0, 1'b0});
            check("rsp_data", bus.rsp_data, e_data);
            check("rsp_meta", {bus.rsp_flags, bus.rsp_err, bus.rsp_tag}, {e_flags, e_err, tag});
            check("sticky", sticky_flags, sticky_m);
            drive_units(int'(op), 1'b0, out, flg);
            bus.req_valid = 1'b1;
            bus.req_opcode = 3'($urandom);
            bus.req_tag = ~tag;
            bus.rsp_ready = (h == hold);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check("post_hs", {bus.rsp_valid, bus.req_ready}, 2'b01);
        check("retain", {bus.rsp_data, bus.rsp_flags, bus.rsp_err}, {e_data, e_flags, e_err});
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_rm = '0;
        bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
        bus.unit_done = '0; bus.unit_out = '0; bus.unit_flags = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Directed cases
        txn(3'd0, 32'h3F800000, 32'h40000000, 4'h5, 3'd0, 4, 32'h40400000, 5'b0, 0, 1'b0, 0);
        txn(3'd6, 32'h12345678, 32'h9ABCDEF0, 4'hA, 3'd1, 0, 32'h0, 5'b0, 2, 1'b0, 0);
        txn(3'd2, 32'h40490FDB, 32'h00000000, 4'h3, 3'd2, NEVER, 32'h0, 5'b0, 0, 1'b0, 0);
        txn(3'd1, 32'hC0000000, 32'h3F000000, 4'h7, 3'd3, 0, 32'hBF800000, 5'b01000, 10, 1'b0, 0);
        txn(3'd3, 32'h1, 32'h2, 4'h9, 3'd4, int'(TO) - 1, 32'hDEADBEEF, 5'b00010, 1, 1'b0, 0);

        // Clear sticky, build old=00001, then clear coinciding with a div_zero response
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        sticky_m = '0;
        check("sticky_clr", sticky_flags, 5'b0);
        txn(3'd3, 32'h5, 32'h6, 4'h1, 3'd0, 2, 32'h11111111, 5'b00001, 0, 1'b0, 0);
        txn(3'd4, 32'h7, 32'h0, 4'h2, 3'd0, 1, 32'h7F800000, 5'b10000, 0, 1'b1, 0);

        // Reset in the middle of RUN abandons the operation
        txn(3'd1, 32'hAAAA5555, 32'h5555AAAA, 4'hC, 3'd1, NEVER, 32'h0, 5'b0, 0, 1'b0, 10);

        // Random traffic
        for (int t = 0; t < 30; t++) begin
            int d, r;
            r = int'($urandom_range(0, 9));
            d = (r == 0) ? NEVER : int'($urandom_range(0, 6));
            txn(3'($urandom_range(0, 7)), $urandom, $urandom, 4'($urandom), 3'($urandom),
                d, $urandom, 5'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
